// File: rtl/led_sequencer.sv
// LED pattern sequencer: runs OFF/BLINK/CHASE/PINGPONG patterns for a step count or until stopped.
// One command at a time; a one-cycle done pulse marks completion and the block returns to idle.
module led_sequencer #(
    parameter int NUM_LEDS    = 8,
    parameter int STEP_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    // Handshake: a command transfers on a rising edge where cmd_valid=1 and cmd_ready=1;
    // cmd_ready is high only in IDLE and nothing is queued while the block is busy.
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic [7:0]          cmd_steps,
    input  logic                stop,
    output logic [NUM_LEDS-1:0] leds,
    output logic                busy,
    output logic                done,
    output logic [1:0]          fsm_state
);

    localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_CYCLES - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [NUM_LEDS-1:0] LED_FIRST = NUM_LEDS'(1);

    localparam logic [1:0] MODE_OFF      = 2'd0;
    localparam logic [1:0] MODE_BLINK    = 2'd1;
    localparam logic [1:0] MODE_CHASE    = 2'd2;
    localparam logic [1:0] MODE_PINGPONG = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [7:0]          count_q, count_d;
    logic                dir_q, dir_d;
    logic [1:0]          mode_q, mode_d;
    logic [7:0]          steps_q, steps_d;

    logic [NUM_LEDS-1:0] step_leds;
    logic                step_dir;
    logic [7:0]          count_inc;

    // Pattern advance for one step; dir=1 means moving toward bit NUM_LEDS-1.
    always_comb begin
        step_leds = leds_q;
        step_dir  = dir_q;
        case (mode_q)
            MODE_BLINK: step_leds = ~leds_q;
            MODE_CHASE: step_leds = {leds_q[NUM_LEDS-2:0], leds_q[NUM_LEDS-1]};
            MODE_PINGPONG: begin
                if (dir_q) begin
                    if (leds_q[NUM_LEDS-1]) begin
                        step_leds = leds_q >> 1;
                        step_dir  = 1'b0;
                    end else begin
                        step_leds = leds_q << 1;
                    end
                end else begin
                    if (leds_q[0]) begin
                        step_leds = leds_q << 1;
                        step_dir  = 1'b1;
                    end else begin
                        step_leds = leds_q >> 1;
                    end
                end
            end
            default: step_leds = leds_q;
        endcase
    end

    assign count_inc = count_q + 8'd1;

    always_comb begin
        state_d = state_q;
        leds_d  = leds_q;
        presc_d = presc_q;
        count_d = count_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        steps_d = steps_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    mode_d  = cmd_mode;
                    steps_d = cmd_steps;
                    presc_d = '0;
                    count_d = '0;
                    dir_d   = 1'b1;
                    if (cmd_mode == MODE_OFF) begin
                        state_d = S_DONE;
                        leds_d  = '0;
                    end else begin
                        state_d = S_RUN;
                        leds_d  = (cmd_mode == MODE_BLINK) ? '1 : LED_FIRST;
                    end
                end
            end
            S_RUN: begin
                // stop outranks a coincident terminal step, so only one DONE entry happens
                if (stop) begin
                    state_d = S_DONE;
                    leds_d  = '0;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    count_d = count_inc;
                    leds_d  = step_leds;
                    dir_d   = step_dir;
                    if (steps_q != 8'd0 && count_inc == steps_q) begin
                        state_d = S_DONE;
                        leds_d  = '0;
                    end
                end else begin
                    presc_d = presc_q + PRESC_ONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            leds_q  <= '0;
            presc_q <= '0;
            count_q <= '0;
            dir_q   <= 1'b1;
            mode_q  <= MODE_OFF;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            leds_q  <= leds_d;
            presc_q <= presc_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            steps_q <= steps_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign leds      = leds_q;
    assign fsm_state = state_q;

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_LEDS, default 8, giving the LED count (legal 2..32).
REQ-002 The block SHALL have parameter STEP_CYCLES, default 8, giving clock cycles per pattern step (legal 2..65535).
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 Port: cmd_valid  input  1  command request.
REQ-006 Port: cmd_ready  output  1  the block accepts a command this cycle.
REQ-007 Port: cmd_mode  input  2  pattern: 0 OFF, 1 BLINK, 2 CHASE, 3 PINGPONG.
REQ-008 Port: cmd_steps  input  8  steps to run; 0 means run until stopped.
REQ-009 Port: stop  input  1  abort request while running.
REQ-010 Port: leds  output  NUM_LEDS  registered LED drive, bit 0 = first LED.
REQ-011 Port: busy  output  1  high while in RUN.
REQ-012 Port: done  output  1  one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE; cmd_ready SHALL be 1 exactly in IDLE.
REQ-014 A command SHALL be accepted on an edge where cmd_valid=1 and cmd_ready=1; cmd_mode and cmd_steps SHALL be latched at that edge.
REQ-015 On acceptance with mode OFF, the FSM SHALL go to DONE with leds=0.
REQ-016 On acceptance with any other mode, the FSM SHALL go to RUN, clear the prescaler and step counter, and load leds with all-ones for BLINK, or 1 (bit 0) for CHASE and PINGPONG; PINGPONG direction SHALL be set to up.
REQ-017 In RUN, the prescaler SHALL count 0..STEP_CYCLES-1 and wrap; a step SHALL occur on the edge where it equals STEP_CYCLES-1, so the first step lands STEP_CYCLES cycles after acceptance.
REQ-018 A BLINK step SHALL invert all leds bits.
REQ-019 A CHASE step SHALL rotate leds left by one, with bit NUM_LEDS-1 wrapping to bit 0.
REQ-020 A PINGPONG step SHALL shift the single set bit one position in the current direction, reversing direction on reaching bit NUM_LEDS-1 or bit 0 without repeating the end bit (NUM_LEDS=8: 01,02,..,80,40,..,01,02).
REQ-021 Each step SHALL increment the step counter; when cmd_steps is nonzero and the incremented count equals cmd_steps, the FSM SHALL go to DONE on that same edge.
REQ-022 When cmd_steps=0, the step counter SHALL have no effect and RUN SHALL persist until stop.
REQ-023 stop=1 in RUN SHALL move the FSM to DONE on the next edge; stop SHALL be ignored in IDLE and DONE.
REQ-024 When stop and the terminal step coincide, the FSM SHALL take one transition to DONE and produce exactly one done pulse.
REQ-025 On entry to DONE, leds SHALL be cleared to 0; the FSM SHALL stay in DONE for exactly one cycle, during which done=1, then return to IDLE.
REQ-026 cmd_valid SHALL be ignored outside IDLE and SHALL NOT be queued.
REQ-027 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).

Reset
REQ-028 While rst=0 at an edge, the block SHALL set state=IDLE, leds=0, prescaler=0, step counter=0 and direction=up, so that after reset cmd_ready=1, busy=0 and done=0.
REQ-029 Reset asserted mid-RUN or in DONE SHALL abort without producing a done pulse.

Verification
REQ-030 Reset, then mode=1 with steps=4 and STEP_CYCLES=8 -> leds=FF for 8 cycles, then 00, FF, 00, 00; done pulses 32 cycles after acceptance; cmd_ready returns 1 on the following cycle.
REQ-031 Mode=2 with steps=9 and NUM_LEDS=8 -> leds go 01,02,..,80,01, then 00 with done.
REQ-032 Mode=3 with steps=0 -> leds go 01,02,..,80,40,..,01,02 with no reversal glitch; busy stays 1 until stop=1, then done pulses once and leds=00.
REQ-033 stop asserted on the terminal-step edge -> exactly one done pulse, and the FSM is back in IDLE two cycles later.
REQ-034 cmd_valid held during RUN with a different mode -> the pattern is unchanged; after done, the held command is accepted once IDLE is reached.
REQ-035 rst=0 mid-CHASE -> on the next edge leds=00, cmd_ready=1 and done=0.
